// File: rtl/mem_access_pkg.sv
// Shared data-bus types and the M-stage memory FSM state used by mem_access.
package mem_access_pkg;

    localparam int unsigned WORD_W   = 32;
    localparam int unsigned STROBE_W = 4;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [WORD_W-1:0] addr_t;

    localparam logic [STROBE_W-1:0] STROBE_WORD = 4'hF;
    localparam logic [STROBE_W-1:0] STROBE_NONE = 4'h0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } memState_t;

    typedef struct packed {
        logic                valid;
        addr_t               addr;
        logic [STROBE_W-1:0] strobe;
        word_t               data;
    } dbus_req_t;

    typedef struct packed {
        logic  addr_ok;
        logic  data_ok;
        word_t data;
    } dbus_resp_t;

endpackage

// File: rtl/mem_access.sv
// M-stage data-bus access: issues one dbus transaction per load/store,
// stalls the pipeline until it completes and holds the load result.
module mem_access
    import mem_access_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        MemtoRegM,
    input  logic        MemWriteM,
    input  logic [31:0] ALUOutM,
    input  logic [31:0] WriteDataM,
    input  logic        StallExt,
    output dbus_req_t   dreq,
    input  dbus_resp_t  dresp,
    output logic [31:0] ReadDataM,
    output logic        StallMem
);

    memState_t state;
    memState_t stateNext;
    logic      access;
    logic      isLoad;
    logic      reqValid;
    logic      loadCapture;

    // A store wins when both request bits are set.
    assign access = MemtoRegM | MemWriteM;
    assign isLoad = MemtoRegM & ~MemWriteM;

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state, request valid and load-capture strobe.
    always_comb begin
        stateNext   = state;
        reqValid    = 1'b0;
        loadCapture = 1'b0;
        case (state)
            IDLE: begin
                reqValid = access;
                if (access) begin
                    if (dresp.addr_ok && dresp.data_ok) begin
                        stateNext   = DONE;
                        loadCapture = isLoad;
                    end else if (dresp.addr_ok) begin
                        stateNext = DATA;
                    end else begin
                        stateNext = ADDR;
                    end
                end
            end
            ADDR: begin
                reqValid = 1'b1;
                if (dresp.addr_ok && dresp.data_ok) begin
                    stateNext   = DONE;
                    loadCapture = isLoad;
                end else if (dresp.addr_ok) begin
                    stateNext = DATA;
                end
            end
            DATA: begin
                if (dresp.data_ok) begin
                    stateNext   = DONE;
                    loadCapture = isLoad;
                end
            end
            DONE: begin
                if (!StallExt) begin
                    stateNext = IDLE;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Load result, held across stalls and untouched by stores.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ReadDataM <= '0;
        end else if (loadCapture) begin
            ReadDataM <= dresp.data;
        end
    end

    // Request payload comes straight from the frozen M-stage register.
    always_comb begin
        dreq        = '0;
        dreq.valid  = resetn & reqValid;
        dreq.addr   = ALUOutM & ~32'h0000_0003;
        dreq.strobe = MemWriteM ? STROBE_WORD : STROBE_NONE;
        dreq.data   = WriteDataM;
    end

    assign StallMem = resetn & access & (state != DONE);

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 SHALL have: clk  in  1  single clock; all state rising-edge.
REQ-002 SHALL have: resetn  in  1  reset; asynchronous, active-low.
REQ-003 SHALL have: MemtoRegM  in  1  M-stage load request.
REQ-004 SHALL have: MemWriteM  in  1  M-stage store request.
REQ-005 SHALL have: ALUOutM  in  32  byte address of the access.
REQ-006 SHALL have: WriteDataM  in  32  store data.
REQ-007 SHALL have: StallExt  in  1  stall of the M stage from all sources other than this block.
REQ-008 SHALL have: dreq  out  dbus_req_t  {valid, addr[31:0], strobe[3:0], data[31:0]}.
REQ-009 SHALL have: dresp  in  dbus_resp_t  {addr_ok, data_ok, data[31:0]}.
REQ-010 SHALL have: ReadDataM  out  32  load result; valid while state==DONE.
REQ-011 SHALL have: StallMem  out  1  holds the E/M and earlier stages while the access is incomplete.

Function
REQ-012 SHALL define access = MemtoRegM | MemWriteM; MemtoRegM & MemWriteM both high SHALL be treated as a store.
REQ-013 SHALL implement FSM states IDLE, ADDR, DATA, DONE; reset state IDLE.
REQ-014 IDLE: dreq.valid = access; if access & addr_ok & data_ok -> DONE; access & addr_ok & ~data_ok -> DATA; access & ~addr_ok -> ADDR; ~access -> IDLE.
REQ-015 ADDR: dreq.valid = 1; addr_ok & data_ok -> DONE; addr_ok only -> DATA; else stay.
REQ-016 DATA: dreq.valid = 0; data_ok -> DONE; else stay.
REQ-017 DONE: dreq.valid = 0; ~StallExt -> IDLE; StallExt -> stay (result held).
REQ-018 dreq.addr SHALL be ALUOutM with bits[1:0] forced to 0; dreq.data SHALL be WriteDataM.
REQ-019 dreq.strobe SHALL be 4'hF for stores and 4'h0 for loads.
REQ-020 ReadDataM SHALL be a register loaded from dresp.data on the data_ok cycle of a load (IDLE/ADDR/DATA states) and held otherwise, including across StallExt.
REQ-021 Stores SHALL NOT modify ReadDataM.
REQ-022 StallMem SHALL be access & (state != DONE); it SHALL NOT depend combinationally on dresp (response-to-stall path is registered through the FSM).
REQ-023 Minimum access latency: request issued cycle N, addr_ok&data_ok at N -> DONE at N+1, StallMem low at N+1.
REQ-024 dreq.addr/strobe/data SHALL be stable while dreq.valid is high and addr_ok is low (guaranteed because StallMem freezes the M-stage register).
REQ-025 dresp.data_ok outside an outstanding access SHALL be ignored.
REQ-026 Exactly one dbus transaction SHALL be issued per M-stage memory instruction; DONE->IDLE with a new instruction present SHALL begin its request in the following IDLE cycle, not in DONE.

Reset
REQ-027 On resetn low, asynchronously: state=IDLE, ReadDataM=0; combinationally dreq.valid=0, StallMem=0 while in reset.
REQ-028 Reset mid-transaction (ADDR/DATA/DONE) SHALL abandon the transaction; any later stale data_ok SHALL be ignored per REQ-025.

Structure
REQ-029 dbus_req_t, dbus_resp_t and the FSM state enum SHALL live in the shared type package (mycpu/type.svh); word_t/addr_t SHALL be reused.
REQ-030 Single module; no sub-module. Target 120-250 lines.

Verification
REQ-031 Load, ALUOutM=0x8000_0010, addr_ok&data_ok same cycle, data=0xDEAD_BEEF -> valid 1 cycle, strobe 0, StallMem 1 cycle, ReadDataM=0xDEAD_BEEF next cycle.
REQ-032 Store, ALUOutM=0x8000_0023, WriteDataM=0x1234_5678, addr_ok after 3 cycles, data_ok 2 later -> addr=0x8000_0020, strobe F, valid held 4 cycles, StallMem drops 1 cycle after data_ok, ReadDataM unchanged.
REQ-033 Load completes while StallExt=1 for 3 cycles -> FSM stays DONE, no second request, ReadDataM stable, StallMem=0.
REQ-034 Back-to-back loads (0x100 then 0x104, zero-wait bus) -> two distinct requests separated by one DONE cycle; ReadDataM tracks each response.
REQ-035 resetn low in DATA state, later spurious data_ok=1 data=0xFFFF_FFFF -> state IDLE, ReadDataM=0, no request.
REQ-036 Both MemtoRegM and MemWriteM high -> strobe F, treated as store.
